// File: rtl/parking_pkg.sv
// Shared types and default constants for the parking gate controller.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_OPEN = 2'd1,
    EXIT_OPEN  = 2'd2
  } gate_state_t;

  localparam int PARKING_CAPACITY   = 8;
  localparam int PARKING_GATE_TICKS = 5;

endpackage

// File: rtl/rise_detect.sv
// One-bit registered rising-edge detector; the previous-value register resets to RST_VAL.
module rise_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev_p0;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) prev_p0 <= RST_VAL;
    else     prev_p0 <= d;
  end

  assign rise = d & ~prev_p0;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry/exit barrier controller with occupancy tracking and tick-based gate timeout.
// Optional PARKING_GATE_STATS_EN adds a saturating total_entries counter.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY   = PARKING_CAPACITY,
  parameter int CNT_W      = 4,
  parameter int GATE_TICKS = PARKING_GATE_TICKS
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             car_pass,
  output logic             entry_gate,
  output logic             exit_gate,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             reject,
  output logic             timeout
`ifdef PARKING_GATE_STATS_EN
  ,
  output logic [15:0]      total_entries
`endif
);

  localparam int               TMR_W    = $clog2(GATE_TICKS + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GATE_TICKS);
  localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);

  logic tick_rise, entry_rise, exit_rise, pass_rise;

  // tick_in idles high after reset, so its history starts at 1 to avoid a phantom tick
  rise_detect #(.RST_VAL(1'b1)) u_tick  (.clk_in(clk_in), .rst(rst), .d(tick_in),   .rise(tick_rise));
  rise_detect #(.RST_VAL(1'b0)) u_entry (.clk_in(clk_in), .rst(rst), .d(entry_req), .rise(entry_rise));
  rise_detect #(.RST_VAL(1'b0)) u_exit  (.clk_in(clk_in), .rst(rst), .d(exit_req),  .rise(exit_rise));
  rise_detect #(.RST_VAL(1'b0)) u_pass  (.clk_in(clk_in), .rst(rst), .d(car_pass),  .rise(pass_rise));

  gate_state_t      state, state_nx;
  logic [TMR_W-1:0] timer, timer_nx;
  logic [CNT_W-1:0] occ_nx;
  logic             pend_entry, pend_entry_nx, pend_exit, pend_exit_nx;
  logic             reject_nx, timeout_nx;
  logic             entry_any, exit_any;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      occupancy  <= '0;
      pend_entry <= 1'b0;
      pend_exit  <= 1'b0;
      reject     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      occupancy  <= occ_nx;
      pend_entry <= pend_entry_nx;
      pend_exit  <= pend_exit_nx;
      reject     <= reject_nx;
      timeout    <= timeout_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    timer_nx      = timer;
    occ_nx        = occupancy;
    pend_entry_nx = pend_entry;
    pend_exit_nx  = pend_exit;
    reject_nx     = 1'b0;
    timeout_nx    = 1'b0;
    entry_any     = entry_rise | pend_entry;
    exit_any      = exit_rise | pend_exit;
    case (state)
      IDLE: begin
        // exit wins; a simultaneous entry stays parked in its pending slot
        if (exit_any && !empty) begin
          state_nx      = EXIT_OPEN;
          timer_nx      = TMR_LOAD;
          pend_exit_nx  = 1'b0;
          pend_entry_nx = entry_any;
        end else if (entry_any && !full) begin
          state_nx      = ENTRY_OPEN;
          timer_nx      = TMR_LOAD;
          pend_entry_nx = 1'b0;
          pend_exit_nx  = 1'b0;
          reject_nx     = exit_any;
        end else begin
          reject_nx     = entry_any | exit_any;
          pend_entry_nx = 1'b0;
          pend_exit_nx  = 1'b0;
        end
      end
      ENTRY_OPEN, EXIT_OPEN: begin
        pend_entry_nx = pend_entry | entry_rise;
        pend_exit_nx  = pend_exit | exit_rise;
        if (pass_rise) begin
          state_nx = IDLE;
          timer_nx = '0;
          if (state == ENTRY_OPEN) begin
            if (!full) occ_nx = occupancy + 1'b1;
          end else begin
            if (!empty) occ_nx = occupancy - 1'b1;
          end
        end else if (tick_rise) begin
          if (timer == TMR_W'(1)) begin
            state_nx   = IDLE;
            timer_nx   = '0;
            timeout_nx = 1'b1;
          end else begin
            timer_nx = timer - 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    entry_gate = (state == ENTRY_OPEN);
    exit_gate  = (state == EXIT_OPEN);
    full       = (occupancy == CAP);
    empty      = (occupancy == '0);
  end

`ifdef PARKING_GATE_STATS_EN
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) total_entries <= '0;
    else if (state == ENTRY_OPEN && pass_rise && !full && total_entries != 16'hFFFF)
      total_entries <= total_entries + 16'd1;
  end
`endif

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl at CAPACITY=2, GATE_TICKS=5.
module tb_parking_gate_ctrl;

  localparam int CAP = 2;
  localparam int CW  = 4;
  localparam int GT  = 5;

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          tick_in = 1'b1;
  logic          entry_req = 1'b0;
  logic          exit_req = 1'b0;
  logic          car_pass = 1'b0;
  logic          entry_gate, exit_gate, full, empty, reject, timeout;
  logic [CW-1:0] occupancy;
`ifdef PARKING_GATE_STATS_EN
  logic [15:0]   total_entries;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk_in = ~clk_in;

  parking_gate_ctrl #(.CAPACITY(CAP), .CNT_W(CW), .GATE_TICKS(GT)) dut (
    .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .entry_req(entry_req),
    .exit_req(exit_req), .car_pass(car_pass), .entry_gate(entry_gate),
    .exit_gate(exit_gate), .occupancy(occupancy), .full(full), .empty(empty),
    .reject(reject), .timeout(timeout)
`ifdef PARKING_GATE_STATS_EN
    , .total_entries(total_entries)
`endif
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic tick_pulse();
    tick_in = 1'b0; cyc(1);
    tick_in = 1'b1; cyc(1);
  endtask

  task automatic do_entry_pass();
    entry_req = 1'b1; cyc(1);
    entry_req = 1'b0; cyc(1);
    car_pass = 1'b1; cyc(1);
    car_pass = 1'b0; cyc(1);
  endtask

  task automatic do_exit_pass();
    exit_req = 1'b1; cyc(1);
    exit_req = 1'b0; cyc(1);
    car_pass = 1'b1; cyc(1);
    car_pass = 1'b0; cyc(1);
  endtask

  task automatic test_reset();
    cyc(2);
    n_total++; if (entry_gate !== 1'b0 || exit_gate !== 1'b0) begin n_bad++; $display("FAIL rst_gates: got %b%b want 00", entry_gate, exit_gate); end
    n_total++; if (occupancy !== 4'd0) begin n_bad++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
    n_total++; if (empty !== 1'b1 || full !== 1'b0) begin n_bad++; $display("FAIL rst_flags: empty=%b full=%b want 1 0", empty, full); end
    n_total++; if (reject !== 1'b0 || timeout !== 1'b0) begin n_bad++; $display("FAIL rst_pulses: rej=%b to=%b want 0 0", reject, timeout); end
    rst = 1'b0;
    cyc(3);
    n_total++; if (entry_gate !== 1'b0 || exit_gate !== 1'b0 || occupancy !== 4'd0 || empty !== 1'b1)
      begin n_bad++; $display("FAIL post_rst_idle: gates=%b%b occ=%0d empty=%b want 00 0 1", entry_gate, exit_gate, occupancy, empty); end
  endtask

  task automatic test_entry_pass();
    entry_req = 1'b1;
    n_total++; if (entry_gate !== 1'b0) begin n_bad++; $display("FAIL entry_pre: got %b want 0", entry_gate); end
    cyc(1);
    n_total++; if (entry_gate !== 1'b1) begin n_bad++; $display("FAIL entry_c1: got %b want 1", entry_gate); end
    entry_req = 1'b0;
    cyc(1);
    n_total++; if (entry_gate !== 1'b1) begin n_bad++; $display("FAIL entry_c2: got %b want 1", entry_gate); end
    cyc(1);
    n_total++; if (entry_gate !== 1'b1) begin n_bad++; $display("FAIL entry_c3: got %b want 1", entry_gate); end
    car_pass = 1'b1;
    cyc(1);
    n_total++; if (entry_gate !== 1'b0) begin n_bad++; $display("FAIL entry_close: got %b want 0", entry_gate); end
    n_total++; if (occupancy !== 4'd1 || empty !== 1'b0 || full !== 1'b0) begin n_bad++; $display("FAIL entry_occ: occ=%0d empty=%b full=%b want 1 0 0", occupancy, empty, full); end
    car_pass = 1'b0;
    cyc(1);
  endtask

  task automatic test_full_reject();
    do_entry_pass();
    n_total++; if (occupancy !== 4'd2 || full !== 1'b1) begin n_bad++; $display("FAIL fill: occ=%0d full=%b want 2 1", occupancy, full); end
    entry_req = 1'b1;
    cyc(1);
    n_total++; if (reject !== 1'b1 || entry_gate !== 1'b0) begin n_bad++; $display("FAIL full_reject: rej=%b gate=%b want 1 0", reject, entry_gate); end
    entry_req = 1'b0;
    cyc(1);
    n_total++; if (reject !== 1'b0 || entry_gate !== 1'b0 || full !== 1'b1) begin n_bad++; $display("FAIL reject_len: rej=%b gate=%b full=%b want 0 0 1", reject, entry_gate, full); end
    cyc(2);
    n_total++; if (entry_gate !== 1'b0 || occupancy !== 4'd2) begin n_bad++; $display("FAIL reject_stays: gate=%b occ=%0d want 0 2", entry_gate, occupancy); end
  endtask

  task automatic test_timeout();
    do_exit_pass();
    n_total++; if (occupancy !== 4'd1) begin n_bad++; $display("FAIL exit_occ: got %0d want 1", occupancy); end
    entry_req = 1'b1; cyc(1);
    entry_req = 1'b0;
    for (int i = 1; i < GT; i++) begin
      tick_pulse();
      n_total++; if (entry_gate !== 1'b1 || timeout !== 1'b0) begin n_bad++; $display("FAIL tick_%0d: gate=%b to=%b want 1 0", i, entry_gate, timeout); end
    end
    tick_pulse();
    n_total++; if (timeout !== 1'b1 || entry_gate !== 1'b0) begin n_bad++; $display("FAIL timeout_hit: to=%b gate=%b want 1 0", timeout, entry_gate); end
    n_total++; if (occupancy !== 4'd1) begin n_bad++; $display("FAIL timeout_occ: got %0d want 1", occupancy); end
    cyc(1);
    n_total++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL timeout_len: got %b want 0", timeout); end
  endtask

  task automatic test_pass_wins();
    entry_req = 1'b1; cyc(1);
    entry_req = 1'b0;
    for (int i = 1; i < GT; i++) tick_pulse();
    n_total++; if (entry_gate !== 1'b1) begin n_bad++; $display("FAIL pw_open: got %b want 1", entry_gate); end
    tick_in = 1'b0; cyc(1);
    tick_in = 1'b1; car_pass = 1'b1; cyc(1);
    n_total++; if (timeout !== 1'b0 || entry_gate !== 1'b0 || occupancy !== 4'd2) begin n_bad++; $display("FAIL pass_wins: to=%b gate=%b occ=%0d want 0 0 2", timeout, entry_gate, occupancy); end
    car_pass = 1'b0; cyc(1);
    n_total++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL pw_late_to: got %b want 0", timeout); end
    do_exit_pass();
  endtask

  task automatic test_back_to_back();
    entry_req = 1'b1; exit_req = 1'b1;
    cyc(1);
    n_total++; if (exit_gate !== 1'b1 || entry_gate !== 1'b0) begin n_bad++; $display("FAIL prio: exit=%b entry=%b want 1 0", exit_gate, entry_gate); end
    entry_req = 1'b0; exit_req = 1'b0;
    cyc(1);
    car_pass = 1'b1; cyc(1);
    n_total++; if (exit_gate !== 1'b0 || entry_gate !== 1'b0 || occupancy !== 4'd0) begin n_bad++; $display("FAIL b2b_close: exit=%b entry=%b occ=%0d want 0 0 0", exit_gate, entry_gate, occupancy); end
    car_pass = 1'b0; cyc(1);
    n_total++; if (entry_gate !== 1'b1) begin n_bad++; $display("FAIL b2b_pending: got %b want 1", entry_gate); end
    car_pass = 1'b1; cyc(1);
    n_total++; if (entry_gate !== 1'b0 || occupancy !== 4'd1) begin n_bad++; $display("FAIL b2b_final: gate=%b occ=%0d want 0 1", entry_gate, occupancy); end
    car_pass = 1'b0; cyc(1);
  endtask

  task automatic test_exit_empty();
    do_exit_pass();
    n_total++; if (empty !== 1'b1 || occupancy !== 4'd0) begin n_bad++; $display("FAIL drain: empty=%b occ=%0d want 1 0", empty, occupancy); end
    exit_req = 1'b1; cyc(1);
    n_total++; if (reject !== 1'b1 || exit_gate !== 1'b0) begin n_bad++; $display("FAIL empty_reject: rej=%b gate=%b want 1 0", reject, exit_gate); end
    exit_req = 1'b0; cyc(1);
    n_total++; if (reject !== 1'b0 || exit_gate !== 1'b0) begin n_bad++; $display("FAIL empty_rej_len: rej=%b gate=%b want 0 0", reject, exit_gate); end
  endtask

  task automatic test_reset_midop();
    do_entry_pass();
`ifdef PARKING_GATE_STATS_EN
    n_total++; if (total_entries !== 16'd5) begin n_bad++; $display("FAIL stats_count: got %0d want 5", total_entries); end
`endif
    entry_req = 1'b1; cyc(1);
    entry_req = 1'b0;
    n_total++; if (entry_gate !== 1'b1 || occupancy !== 4'd1) begin n_bad++; $display("FAIL mid_open: gate=%b occ=%0d want 1 1", entry_gate, occupancy); end
    #3 rst = 1'b1;
    #1;
    n_total++; if (entry_gate !== 1'b0) begin n_bad++; $display("FAIL async_gate: got %b want 0", entry_gate); end
    n_total++; if (occupancy !== 4'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL async_occ: occ=%0d empty=%b want 0 1", occupancy, empty); end
`ifdef PARKING_GATE_STATS_EN
    n_total++; if (total_entries !== 16'd0) begin n_bad++; $display("FAIL stats_rst: got %0d want 0", total_entries); end
`endif
    cyc(1);
    rst = 1'b0;
    cyc(1);
  endtask

  initial begin
    test_reset();
    test_entry_pass();
    test_full_reject();
    test_timeout();
    test_pass_wins();
    test_back_to_back();
    test_exit_empty();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Entry/exit gate controller for the parking lot, sitting directly downstream of the clock divider. It samples the divider's slow square wave `clk_out` as a tick enable in the fast `clk_in` domain and runs the gate-open timeout in those ticks. It accepts entry and exit requests, opens the matching barrier, and tracks lot occupancy against a fixed capacity. It exports occupancy, full and empty status for the display stage.

## Interface
Parameters:
- CAPACITY, 8: number of spaces; must be at least 1.
- CNT_W, 4: occupancy width; 2^CNT_W must exceed CAPACITY.
- GATE_TICKS, 5: gate-open timeout in tick edges; must be at least 1.

Ports:
- clk_in  in  1  system clock; the same clock that drives the divider.
- rst  in  1  asynchronous, active-high reset.
- tick_in  in  1  divider `clk_out` level; each rising edge is one tick.
- entry_req  in  1  entry sensor level; each rising edge is a request.
- exit_req  in  1  exit sensor level; each rising edge is a request.
- car_pass  in  1  barrier pass sensor level; a rising edge means a car went through.
- entry_gate  out  1  entry barrier open.
- exit_gate  out  1  exit barrier open.
- occupancy  out  CNT_W  cars currently inside.
- full  out  1  occupancy == CAPACITY.
- empty  out  1  occupancy == 0.
- reject  out  1  one-cycle pulse: request refused.
- timeout  out  1  one-cycle pulse: gate closed with no car passing.

## Operation
- Edge detection on all four level inputs, registered on clk_in.
  - Previous-value register for tick_in resets to 1, so no spurious tick occurs after reset.
  - Previous-value registers for the other inputs reset to 0.
- FSM states: IDLE, ENTRY_OPEN, EXIT_OPEN.
- IDLE:
  - Exit request (or pending exit), not empty: go to EXIT_OPEN, load timer = GATE_TICKS.
  - Else entry request (or pending entry), not full: go to ENTRY_OPEN, load timer.
  - Entry while full, or exit while empty: pulse reject, stay in IDLE.
  - Exit has priority when both are present; the entry is kept as pending.
- ENTRY_OPEN / EXIT_OPEN:
  - car_pass edge: occupancy +1 (entry) or −1 (exit); go to IDLE.
  - Tick edge with timer == 1: pulse timeout; go to IDLE; occupancy unchanged.
  - Other tick edge: timer −1.
  - car_pass edge and final tick in the same cycle: the pass wins and no timeout is raised.
- Requests arriving while a gate is open set pending_entry / pending_exit; there is one slot per direction and extra requests collapse into it.
- A pending flag clears when served or rejected.
- A car_pass edge in IDLE is ignored.
- Occupancy never wraps: it is guarded by the full/empty checks.
- Outputs are registered:
  - entry_gate = (state == ENTRY_OPEN); exit_gate = (state == EXIT_OPEN).
  - full and empty are derived from the registered occupancy.

## Timing
- Reset values: IDLE, timer 0, occupancy 0, empty 1, full 0, both gates 0, reject 0, timeout 0, pending flags 0.
- Reset asserted mid-operation closes both gates immediately (asynchronously) and loses the count.
- Input edge at cycle N is detected in cycle N. The gate output is high from cycle N+1.
- Pass edge at cycle M: gate low at M+1; occupancy updated at M+1.
- A pending request is served on the first cycle after returning to IDLE, so its gate opens 2 cycles after the close.
- Gate stays open for GATE_TICKS tick edges at most. The first interval is partial: between GATE_TICKS−1 and GATE_TICKS tick periods.
- reject and timeout are high for exactly one clk_in cycle.

## Configuration
- `PARKING_GATE_STATS_EN`
  - Defined: adds output `total_entries` [15:0], reset 0. It increments on every entry pass and saturates at 16'hFFFF.
  - Undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Shared package `parking_pkg` holds:
  - the gate_state_t enum (IDLE, ENTRY_OPEN, EXIT_OPEN);
  - default constants PARKING_CAPACITY = 8 and PARKING_GATE_TICKS = 5.
- Sub-module `rise_detect`: one-bit registered rising-edge detector with a parameterised reset value for the previous-value register. It is instantiated four times.

## Test plan
- Reset, then hold tick_in = 1 → no tick counted; empty = 1, occupancy 0, both gates 0.
- Entry edge, car_pass edge 3 cycles later → entry_gate high for 3 cycles, occupancy 1, empty 0.
- CAPACITY = 2: fill to 2, then entry edge → reject pulses 1 cycle, full = 1, entry_gate stays 0.
- Entry edge, no pass, GATE_TICKS = 5 tick edges → timeout pulse on the 5th tick, gate closes, occupancy unchanged.
- Occupancy 1, entry and exit edges in the same cycle → exit_gate opens first. After the exit pass, entry_gate opens 2 cycles later; final occupancy after both passes is 1.
- Reset asserted while entry_gate is open → gate drops without waiting for a clock edge; occupancy 0. With the macro defined, total_entries is also 0.
